// File: rtl/edge_detect_pkg.sv
`default_nettype none
// ============================================================================
// Module   : edge_detect_pkg
// Purpose  : Shared VGA 640x480 timing constants and blanking-total helper
//            for the edge-detect video output path.
// Revision : 1.0 - initial release
// ============================================================================
package edge_detect_pkg;

  // Standard 640x480 @ 60 Hz timing, in pixel clocks (horizontal) or lines
  localparam int VGA_H_ACTIVE    = 640;
  localparam int VGA_H_FRONT     = 16;
  localparam int VGA_H_SYNC      = 96;
  localparam int VGA_H_BACK      = 48;
  localparam int VGA_V_ACTIVE    = 480;
  localparam int VGA_V_FRONT     = 10;
  localparam int VGA_V_SYNC      = 2;
  localparam int VGA_V_BACK      = 33;
  localparam int VGA_PIXEL_DEPTH = 24;
  localparam int VGA_CLK_DIV     = 2;

  // Full period of one scan dimension: active + front porch + sync + back porch
  function automatic int line_total(input int active, input int front,
                                    input int sync, input int back);
    return active + front + sync + back;
  endfunction

endpackage
`default_nettype wire

// File: rtl/frame_line_buffer2.sv
`default_nettype none
// ============================================================================
// Module   : frame_line_buffer2
// Purpose  : Two-bank line store, one write port and one registered read
//            port. Bank selection is left to the caller.
// Revision : 1.0 - initial release
// ============================================================================
module frame_line_buffer2 #(
  parameter int COLUMNS = 640,
  parameter int WIDTH   = 8
) (
  input  logic                       i_clk,
  input  logic                       i_wr_en,
  input  logic                       i_wr_bank,
  input  logic [$clog2(COLUMNS)-1:0] i_wr_addr,
  input  logic [WIDTH-1:0]           i_wr_data,
  input  logic                       i_rd_bank,
  input  logic [$clog2(COLUMNS)-1:0] i_rd_addr,
  output logic [WIDTH-1:0]           o_rd_data
);

  logic [WIDTH-1:0] mem_q [2][COLUMNS];
  logic [WIDTH-1:0] rd_data_q;

  // Storage is not reset: the owner's filled flags decide whether it is used
  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      mem_q[i_wr_bank][i_wr_addr] <= i_wr_data;
    end
    rd_data_q <= mem_q[i_rd_bank][i_rd_addr];
  end

  assign o_rd_data = rd_data_q;

endmodule
`default_nettype wire

// File: rtl/edge_frame_vga_transmitter.sv
`default_nettype none
// ============================================================================
// Module   : edge_frame_vga_transmitter
// Purpose  : Buffers processed grayscale rows in a two-bank line store and
//            scans them out as VGA video (gray replicated onto R, G, B),
//            with underrun/overrun reporting.
// Revision : 1.0 - initial release
// ============================================================================
module edge_frame_vga_transmitter
  import edge_detect_pkg::*;
#(
  parameter int P_FRAME_COLUMNS = VGA_H_ACTIVE,
  parameter int P_FRAME_ROWS    = VGA_V_ACTIVE,
  parameter int P_PIXEL_DEPTH   = VGA_PIXEL_DEPTH,
  parameter int P_H_FRONT       = VGA_H_FRONT,
  parameter int P_H_SYNC        = VGA_H_SYNC,
  parameter int P_H_BACK        = VGA_H_BACK,
  parameter int P_V_FRONT       = VGA_V_FRONT,
  parameter int P_V_SYNC        = VGA_V_SYNC,
  parameter int P_V_BACK        = VGA_V_BACK,
  parameter int P_CLK_DIV       = VGA_CLK_DIV
) (
  input  logic                               I_CLK,
  input  logic                               I_RESET,
  input  logic [$clog2(P_FRAME_COLUMNS)-1:0] I_PIXEL_COLUMN,
  input  logic [$clog2(P_FRAME_ROWS)-1:0]    I_PIXEL_ROW,
  input  logic [P_PIXEL_DEPTH/3-1:0]         I_PIXEL,
  input  logic                               I_PIXEL_VALID,
  output logic                               O_PIXEL_CLK,
  output logic                               O_HSYNC,
  output logic                               O_VSYNC,
  output logic                               O_DATA_VALID,
  output logic [P_PIXEL_DEPTH-1:0]           O_PIXEL,
  output logic                               O_FRAME_START,
  output logic                               O_UNDERRUN,
  output logic                               O_OVERRUN
);

  localparam int COL_W    = $clog2(P_FRAME_COLUMNS);
  localparam int GRAY_W   = P_PIXEL_DEPTH / 3;
  localparam int H_TOTAL  = line_total(P_FRAME_COLUMNS, P_H_FRONT, P_H_SYNC, P_H_BACK);
  localparam int V_TOTAL  = line_total(P_FRAME_ROWS, P_V_FRONT, P_V_SYNC, P_V_BACK);
  localparam int H_W      = $clog2(H_TOTAL);
  localparam int V_W      = $clog2(V_TOTAL);
  localparam int DIV_W    = $clog2(P_CLK_DIV);
  localparam int HS_START = P_FRAME_COLUMNS + P_H_FRONT;
  localparam int HS_END   = HS_START + P_H_SYNC;
  localparam int VS_START = P_FRAME_ROWS + P_V_FRONT;
  localparam int VS_END   = VS_START + P_V_SYNC;

  // h_q/v_q hold the position that the next pixel tick will put on the outputs
  logic [DIV_W-1:0]         div_q, div_d;
  logic [H_W-1:0]           h_q, h_d;
  logic [V_W-1:0]           v_q, v_d;
  logic                     pclk_q, pclk_d;
  logic                     hsync_q, hsync_d;
  logic                     vsync_q, vsync_d;
  logic                     de_q, de_d;
  logic [P_PIXEL_DEPTH-1:0] pixel_q, pixel_d;
  logic                     frame_start_q, frame_start_d;
  logic                     underrun_q, underrun_d;
  logic                     overrun_q, overrun_d;
  logic [1:0]               filled_q, filled_d;
  logic                     row_ok_q, row_ok_d;

  logic                     tick;
  logic                     h_active;
  logic                     v_active;
  logic                     row_start;
  logic                     row_end;
  logic                     row_ok_now;
  logic                     wr_in_range;
  logic                     wr_bank;
  logic                     wr_accept;
  logic                     wr_last;
  logic [COL_W-1:0]         rd_addr;
  logic [GRAY_W-1:0]        rd_data;

  assign tick        = (32'(div_q) == P_CLK_DIV - 1);
  assign h_active    = (32'(h_q) < P_FRAME_COLUMNS);
  assign v_active    = (32'(v_q) < P_FRAME_ROWS);
  assign row_start   = tick && (h_q == '0) && v_active;
  assign row_end     = tick && (32'(h_q) == P_FRAME_COLUMNS) && v_active;
  // The row's fill state is latched at h=0; on that very tick use the live flag
  assign row_ok_now  = (h_q == '0) ? filled_q[v_q[0]] : row_ok_q;

  assign wr_in_range = I_PIXEL_VALID && (32'(I_PIXEL_COLUMN) < P_FRAME_COLUMNS)
                       && (32'(I_PIXEL_ROW) < P_FRAME_ROWS);
  assign wr_bank     = I_PIXEL_ROW[0];
  assign wr_accept   = wr_in_range && !filled_q[wr_bank];
  assign wr_last     = (32'(I_PIXEL_COLUMN) == P_FRAME_COLUMNS - 1);

  // Read address tracks the upcoming position, so data is ready one tick ahead
  assign rd_addr     = h_active ? h_q[COL_W-1:0] : '0;

  frame_line_buffer2 #(
    .COLUMNS (P_FRAME_COLUMNS),
    .WIDTH   (GRAY_W)
  ) u_line_buffer (
    .i_clk     (I_CLK),
    .i_wr_en   (wr_accept),
    .i_wr_bank (wr_bank),
    .i_wr_addr (I_PIXEL_COLUMN),
    .i_wr_data (I_PIXEL),
    .i_rd_bank (v_q[0]),
    .i_rd_addr (rd_addr),
    .o_rd_data (rd_data)
  );

  // Next-state for divider, scan counters, video outputs and buffer flags
  always_comb begin
    div_d         = tick ? '0 : div_q + 1'b1;
    pclk_d        = (32'(div_d) >= P_CLK_DIV / 2);
    h_d           = h_q;
    v_d           = v_q;
    hsync_d       = hsync_q;
    vsync_d       = vsync_q;
    de_d          = de_q;
    pixel_d       = pixel_q;
    frame_start_d = 1'b0;
    underrun_d    = underrun_q;
    overrun_d     = overrun_q;
    filled_d      = filled_q;
    row_ok_d      = row_ok_q;

    if (tick) begin
      if (32'(h_q) == H_TOTAL - 1) begin
        h_d = '0;
        v_d = (32'(v_q) == V_TOTAL - 1) ? '0 : v_q + 1'b1;
      end else begin
        h_d = h_q + 1'b1;
      end

      de_d          = h_active && v_active;
      hsync_d       = !((32'(h_q) >= HS_START) && (32'(h_q) < HS_END));
      vsync_d       = !((32'(v_q) >= VS_START) && (32'(v_q) < VS_END));
      pixel_d       = (h_active && v_active && row_ok_now) ? {3{rd_data}} : '0;
      frame_start_d = (h_q == '0) && (v_q == '0);

      if (row_start) begin
        row_ok_d = filled_q[v_q[0]];
        if (!filled_q[v_q[0]]) begin
          underrun_d = 1'b1;
        end
      end

      // Bank is released once its row has been fully shown
      if (row_end) begin
        filled_d[v_q[0]] = 1'b0;
      end
    end

    if (wr_in_range && filled_q[wr_bank]) begin
      overrun_d = 1'b1;
    end

    // Applied after the release so a completing write keeps the new row
    if (wr_accept && wr_last) begin
      filled_d[wr_bank] = 1'b1;
    end
  end

  // State register with asynchronous reset
  always_ff @(posedge I_CLK or posedge I_RESET) begin
    if (I_RESET) begin
      div_q         <= '0;
      h_q           <= '0;
      v_q           <= '0;
      pclk_q        <= 1'b0;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      de_q          <= 1'b0;
      pixel_q       <= '0;
      frame_start_q <= 1'b0;
      underrun_q    <= 1'b0;
      overrun_q     <= 1'b0;
      filled_q      <= '0;
      row_ok_q      <= 1'b0;
    end else begin
      div_q         <= div_d;
      h_q           <= h_d;
      v_q           <= v_d;
      pclk_q        <= pclk_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      de_q          <= de_d;
      pixel_q       <= pixel_d;
      frame_start_q <= frame_start_d;
      underrun_q    <= underrun_d;
      overrun_q     <= overrun_d;
      filled_q      <= filled_d;
      row_ok_q      <= row_ok_d;
    end
  end

  assign O_PIXEL_CLK   = pclk_q;
  assign O_HSYNC       = hsync_q;
  assign O_VSYNC       = vsync_q;
  assign O_DATA_VALID  = de_q;
  assign O_PIXEL       = pixel_q;
  assign O_FRAME_START = frame_start_q;
  assign O_UNDERRUN    = underrun_q;
  assign O_OVERRUN     = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_edge_frame_vga_transmitter.sv
`default_nettype none
// ============================================================================
// Module   : tb_edge_frame_vga_transmitter
// Purpose  : Directed, table-driven bench for edge_frame_vga_transmitter on a
//            tiny 8x4 frame (H 2/2/2, V 1/1/1, divide-by-2 pixel clock).
// Revision : 1.0 - initial release
// ============================================================================
module tb_edge_frame_vga_transmitter;

  localparam int COLS = 8;
  localparam int ROWS = 4;
  localparam int DIV  = 2;
  localparam int HT   = 14;
  localparam int VT   = 7;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [2:0]  col;
  logic [1:0]  row;
  logic [7:0]  pix;
  logic        valid;
  logic        pclk, hs, vs, de, fs, un, ov;
  logic [23:0] opix;

  edge_frame_vga_transmitter #(
    .P_FRAME_COLUMNS (COLS),
    .P_FRAME_ROWS    (ROWS),
    .P_PIXEL_DEPTH   (24),
    .P_H_FRONT       (2),
    .P_H_SYNC        (2),
    .P_H_BACK        (2),
    .P_V_FRONT       (1),
    .P_V_SYNC        (1),
    .P_V_BACK        (1),
    .P_CLK_DIV       (DIV)
  ) dut (
    .I_CLK          (clk),
    .I_RESET        (rst),
    .I_PIXEL_COLUMN (col),
    .I_PIXEL_ROW    (row),
    .I_PIXEL        (pix),
    .I_PIXEL_VALID  (valid),
    .O_PIXEL_CLK    (pclk),
    .O_HSYNC        (hs),
    .O_VSYNC        (vs),
    .O_DATA_VALID   (de),
    .O_PIXEL        (opix),
    .O_FRAME_START  (fs),
    .O_UNDERRUN     (un),
    .O_OVERRUN      (ov)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         valid;
    logic [1:0] row;
    logic [2:0] col;
    logic [7:0] pix;
  } wr_t;

  typedef struct {
    int          f, h, v;
    logic        hs, vs, de, fs, un, ov;
    logic [23:0] pix;
    int          act;
  } vec_t;

  wr_t  wq[$];
  vec_t vecs[$];

  int n_checks = 0;
  int n_fail   = 0;
  int ph, bh, bv, bf;
  int de_cnt, hs_cnt, vs_cnt;
  bit count_en;

  function automatic logic [23:0] gray3(input int g);
    logic [7:0] b;
    b = 8'(g);
    return {b, b, b};
  endfunction

  function automatic void add(input int f, h, v, input logic e_hs, e_vs, e_de,
                              e_fs, e_un, e_ov, input logic [23:0] e_pix,
                              input int act);
    vec_t r;
    r.f = f; r.h = h; r.v = v;
    r.hs = e_hs; r.vs = e_vs; r.de = e_de; r.fs = e_fs;
    r.un = e_un; r.ov = e_ov; r.pix = e_pix; r.act = act;
    vecs.push_back(r);
  endfunction

  task automatic check(input string name, input logic [31:0] actual,
                       input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // One I_CLK cycle: track the pixel position the outputs now show, then
  // present the next queued write for the following edge.
  task automatic cycle();
    wr_t w;
    @(posedge clk);
    #1;
    ph++;
    if (ph == DIV) begin
      ph = 0;
      if (bh == HT - 1) begin
        bh = 0;
        if (bv == VT - 1) begin bv = 0; bf++; end
        else bv++;
      end else begin
        bh++;
      end
      if (count_en && bf == 0) begin
        if (de === 1'b1) de_cnt++;
        if (hs === 1'b0) hs_cnt++;
        if (vs === 1'b0) vs_cnt++;
      end
    end
    if (wq.size() > 0) begin
      w     = wq.pop_front();
      valid = w.valid;
      row   = w.row;
      col   = w.col;
      pix   = w.pix;
    end else begin
      valid = 1'b0;
    end
  endtask

  task automatic queue_row(input int r, input int base, input int step);
    wr_t w;
    for (int c = 0; c < COLS; c++) begin
      w.valid = 1'b1;
      w.row   = 2'(r);
      w.col   = 3'(c);
      w.pix   = 8'(base + c * step);
      wq.push_back(w);
    end
  endtask

  task automatic advance_to(input int f, input int h, input int v);
    int guard;
    guard = 0;
    while (!(bf == f && bh == h && bv == v) && guard < 1000) begin
      cycle();
      guard++;
    end
    if (guard >= 1000) begin
      n_checks++;
      n_fail++;
      $display("FAIL timeout reaching f%0d h%0d v%0d: got cycles %0d, expected < 1000",
               f, h, v, guard);
    end
  endtask

  task automatic reset_checks(input string tag);
    check({tag, " pixel_clk"}, 32'(pclk), 32'd0);
    check({tag, " hsync"},     32'(hs),   32'd1);
    check({tag, " vsync"},     32'(vs),   32'd1);
    check({tag, " data_valid"},32'(de),   32'd0);
    check({tag, " pixel"},     32'(opix), 32'd0);
    check({tag, " frame_start"},32'(fs),  32'd0);
    check({tag, " underrun"},  32'(un),   32'd0);
    check({tag, " overrun"},   32'(ov),   32'd0);
  endtask

  // Assert reset (checked before any clock edge), hold, release mid-cycle
  task automatic do_reset(input string tag);
    rst   = 1'b1;
    valid = 1'b0;
    wq.delete();
    #1;
    reset_checks(tag);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    ph  = 0;
    bh  = HT - 1;
    bv  = VT - 1;
    bf  = -1;
  endtask

  initial begin
    string tag;
    valid = 1'b0; col = '0; row = '0; pix = '0;
    count_en = 1'b0; de_cnt = 0; hs_cnt = 0; vs_cnt = 0;

    // f, h, v, hs, vs, de, fs, un, ov, pixel, action
    // frame 0: nothing written yet, every row underruns
    add(0, 1, 0, 1, 1, 1, 0, 1, 0, 24'h0, 0);
    add(0, 7, 0, 1, 1, 1, 0, 1, 0, 24'h0, 0);
    add(0, 8, 0, 1, 1, 0, 0, 1, 0, 24'h0, 0);
    add(0, 9, 0, 1, 1, 0, 0, 1, 0, 24'h0, 0);
    add(0,10, 0, 0, 1, 0, 0, 1, 0, 24'h0, 0);
    add(0,11, 0, 0, 1, 0, 0, 1, 0, 24'h0, 0);
    add(0,12, 0, 1, 1, 0, 0, 1, 0, 24'h0, 0);
    add(0,13, 0, 1, 1, 0, 0, 1, 0, 24'h0, 0);
    add(0, 0, 1, 1, 1, 1, 0, 1, 0, 24'h0, 0);
    add(0, 7, 3, 1, 1, 1, 0, 1, 0, 24'h0, 0);
    add(0, 0, 4, 1, 1, 0, 0, 1, 0, 24'h0, 1);
    add(0, 0, 5, 1, 0, 0, 0, 1, 0, 24'h0, 0);
    add(0,10, 5, 0, 0, 0, 0, 1, 0, 24'h0, 0);
    add(0,13, 5, 1, 0, 0, 0, 1, 0, 24'h0, 0);
    add(0, 0, 6, 1, 1, 0, 0, 1, 0, 24'h0, 0);
    // frame 1: row 0 = c*16, row 2 written twice, row 1 never written
    add(1, 0, 0, 1, 1, 1, 1, 1, 0, 24'h0, 6);
    for (int c = 1; c < COLS; c++) add(1, c, 0, 1, 1, 1, 0, 1, 0, gray3(c * 16), 0);
    add(1, 8, 0, 1, 1, 0, 0, 1, 0, 24'h0, 2);
    add(1, 0, 1, 1, 1, 1, 0, 1, 1, 24'h0, 0);
    add(1, 3, 1, 1, 1, 1, 0, 1, 1, 24'h0, 0);
    add(1, 0, 2, 1, 1, 1, 0, 1, 1, 24'h404040, 0);
    add(1, 5, 2, 1, 1, 1, 0, 1, 1, 24'h454545, 0);
    add(1, 7, 2, 1, 1, 1, 0, 1, 1, 24'h474747, 0);
    add(1, 8, 2, 1, 1, 0, 0, 1, 1, 24'h0, 0);
    add(1, 0, 3, 1, 1, 1, 0, 1, 1, 24'h0, 0);
    add(1, 3, 3, 1, 1, 1, 0, 1, 1, 24'h0, 3);
    add(1, 7, 3, 1, 1, 1, 0, 1, 1, 24'h0, 0);
    add(1,10, 3, 0, 1, 0, 0, 1, 1, 24'h0, 0);
    // frame 2: row 1 shows the row completed on the release tick
    add(2, 0, 0, 1, 1, 1, 1, 1, 1, 24'h0, 0);
    add(2, 0, 1, 1, 1, 1, 0, 1, 1, 24'h202020, 0);
    add(2, 4, 1, 1, 1, 1, 0, 1, 1, 24'h242424, 0);
    add(2, 7, 1, 1, 1, 1, 0, 1, 1, 24'h272727, 0);
    add(2, 0, 2, 1, 1, 1, 0, 1, 1, 24'h0, 5);
    add(2, 6, 2, 1, 1, 1, 0, 1, 1, 24'h0, 4);
    // after mid-row reset: fresh frame, pre-reset row 3 data not shown
    add(0, 0, 0, 1, 1, 1, 1, 1, 0, 24'h0, 0);
    add(0, 0, 1, 1, 1, 1, 0, 1, 0, 24'h0, 0);
    add(0, 7, 1, 1, 1, 1, 0, 1, 0, 24'h0, 0);
    add(0,10, 1, 0, 1, 0, 0, 1, 0, 24'h0, 0);

    #2;
    do_reset("reset");
    count_en = 1'b1;
    cycle();
    cycle();
    check("first tick frame_start", 32'(fs), 32'd1);
    check("first tick data_valid", 32'(de), 32'd1);
    cycle();
    check("frame_start one cycle", 32'(fs), 32'd0);
    check("pixel_clk high phase", 32'(pclk), 32'd1);

    for (int i = 0; i < vecs.size(); i++) begin
      advance_to(vecs[i].f, vecs[i].h, vecs[i].v);
      tag = $sformatf("f%0d h%0d v%0d", vecs[i].f, vecs[i].h, vecs[i].v);
      check({tag, " hsync"},       32'(hs),   32'(vecs[i].hs));
      check({tag, " vsync"},       32'(vs),   32'(vecs[i].vs));
      check({tag, " data_valid"},  32'(de),   32'(vecs[i].de));
      check({tag, " frame_start"}, 32'(fs),   32'(vecs[i].fs));
      check({tag, " underrun"},    32'(un),   32'(vecs[i].un));
      check({tag, " overrun"},     32'(ov),   32'(vecs[i].ov));
      check({tag, " pixel"},       32'(opix), 32'(vecs[i].pix));
      case (vecs[i].act)
        1: queue_row(0, 0, 16);
        2: begin
          queue_row(2, 8'h40, 1);
          queue_row(2, 8'h80, 1);
        end
        3: begin
          // idle slot lines the column-7 write up with the row-3 release tick
          wq.push_back('{valid: 1'b0, row: 2'd0, col: 3'd0, pix: 8'd0});
          queue_row(3, 8'h20, 1);
        end
        4: begin
          cycle();
          do_reset("mid-row reset");
        end
        5: queue_row(3, 8'h90, 1);
        6: begin
          check("frame0 data_valid ticks", 32'(de_cnt), 32'd32);
          check("frame0 hsync low ticks",  32'(hs_cnt), 32'd14);
          check("frame0 vsync low ticks",  32'(vs_cnt), 32'd14);
          count_en = 1'b0;
        end
        default: ;
      endcase
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
